// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: bus/instruction types, FSM states, queue entry.
package inst_fetch_unit_pkg;
  typedef logic [63:0] dataBus_t;

  typedef union packed {
    logic [31:0] raw;
    struct packed {
      logic [24:0] rest;
      logic [6:0]  opcode;
    } f;
  } instruction_u;

  typedef enum logic [1:0] {FETCH_S, WAIT_S, FULL_S} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    instruction_u instr;
    dataBus_t     pc;
  } fq_entry_t;
endpackage

// File: rtl/inst_fetch_unit_queue.sv
// fetch_queue: small synchronous FIFO of {instruction, pc}; head is a registered-storage read.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fq_entry_t     wr_data,
  output logic [CW-1:0] count,
  output fq_entry_t     head
);
  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, memory request FSM, redirect handling, fetch queue to decode.
// Optional FETCH_STALL_CNT_EN adds stall_cnt (cycles spent in WAIT_S/FULL_S).
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter dataBus_t RESET_PC    = 64'h0,
  parameter int       QUEUE_DEPTH = 4,
  parameter int       ADDR_SHIFT  = 2
) (
  input  logic         clk,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]  stall_cnt,
`endif
  input  logic         rst,
  input  logic         clk_en,
  input  logic         redirect_en,
  input  dataBus_t     redirect_pc,
  output logic         rd_en,
  output dataBus_t     addr,
  input  instruction_u instruction,
  input  logic         inst_ready,
  output instruction_u if_instr,
  output dataBus_t     if_pc,
  output logic         if_valid,
  input  logic         if_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  fetch_state_e  state_q, state_d;
  dataBus_t      pc_q;
  logic [CW-1:0] count, count_nxt;
  fq_entry_t     head, wr_data;
  logic          active, push, pop, flush;

  // redirect and reset both override push/pop for the cycle
  assign active    = clk_en && !rst && !redirect_en;
  assign if_valid  = !rst && (count != '0);
  assign rd_en     = !rst && (state_q != FULL_S);
  assign addr      = pc_q >> ADDR_SHIFT;
  assign if_instr  = if_valid ? head.instr : instruction_u'(NOP_INSTR);
  assign if_pc     = if_valid ? head.pc : '0;
  assign push      = active && (state_q != FULL_S) && inst_ready && (count != FULL_CNT);
  assign pop       = active && if_valid && if_ready;
  assign flush     = clk_en && (rst || redirect_en);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign wr_data   = '{instr: instruction, pc: pc_q};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .count   (count),
    .head    (head)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_S, WAIT_S: begin
        if (!inst_ready)                                    state_d = WAIT_S;
        else if (count_nxt == FULL_CNT || count == FULL_CNT) state_d = FULL_S;
        else                                                state_d = FETCH_S;
      end
      FULL_S:  if (pop) state_d = FETCH_S;
      default: state_d = FETCH_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (rst) begin
        state_q <= FETCH_S;
        pc_q    <= RESET_PC;
      end else if (redirect_en) begin
        state_q <= FETCH_S;
        pc_q    <= redirect_pc & ~64'h3;
      end else begin
        state_q <= state_d;
        if (push) pc_q <= pc_q + 64'd4;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (rst) stall_cnt <= '0;
      else if ((state_q == WAIT_S || state_q == FULL_S) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
